// File: rtl/sp_ram_obi_arb_pkg.sv
// Shared types for the single-port RAM arbiter between the instruction and data OBI ports.
package sp_ram_arb_pkg;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  we;
        logic  err;
    } rsp_state_t;

endpackage

// File: rtl/sp_ram_obi_arb_if.sv
// Bus bundle: instruction OBI port, data OBI port and the RAM-side signals of the arbiter.
interface sp_ram_obi_arb_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  instr_req;
    logic                  instr_gnt;
    logic [31:0]           instr_addr;
    logic                  instr_rvalid;
    logic [31:0]           instr_rdata;
    logic                  instr_err;

    logic                  data_req;
    logic                  data_gnt;
    logic [31:0]           data_addr;
    logic                  data_we;
    logic [3:0]            data_be;
    logic [31:0]           data_wdata;
    logic                  data_rvalid;
    logic [31:0]           data_rdata;
    logic                  data_err;

    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    modport slave (
        input  instr_req, instr_addr,
        input  data_req, data_addr, data_we, data_be, data_wdata,
        input  ram_rdata,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err,
        output data_gnt, data_rvalid, data_rdata, data_err,
        output ram_en, ram_addr, ram_we, ram_be, ram_wdata
    );

    modport master (
        output instr_req, instr_addr,
        output data_req, data_addr, data_we, data_be, data_wdata,
        output ram_rdata,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
        input  data_gnt, data_rvalid, data_rdata, data_err,
        input  ram_en, ram_addr, ram_we, ram_be, ram_wdata
    );

endinterface

// File: rtl/sp_ram_rr_arb2.sv
// Two-way request picker: round-robin or fixed data priority; remembers the last granted port.
module sp_ram_rr_arb2
    import sp_ram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       mode,
    output logic [1:0] gnt
);

    port_e last_q;

    // Bit 0 is the instruction port, bit 1 the data port.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (mode == ARB_FIXED || last_q == PORT_INSTR) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= PORT_INSTR;
        end else if (gnt[1]) begin
            last_q <= PORT_DATA;
        end else if (gnt[0]) begin
            last_q <= PORT_INSTR;
        end
    end

endmodule

// File: rtl/sp_ram_obi_arb.sv
// Shares one 1-cycle-latency single-port RAM between the instruction and data OBI ports.
module sp_ram_obi_arb
    import sp_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int ARB_MODE   = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sp_ram_obi_arb_if.slave   bus
);

    localparam logic MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:ADDR_WIDTH] == '0;
    endfunction

    logic [1:0]  gnt;
    logic        win_data;
    logic        any_gnt;
    logic [31:0] sel_addr;
    logic        sel_ok;
    rsp_state_t  rsp_q;
    logic        rsp_rd_ok;

    sp_ram_rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    ({bus.data_req, bus.instr_req}),
        .mode   (MODE),
        .gnt    (gnt)
    );

    assign bus.instr_gnt = gnt[0];
    assign bus.data_gnt  = gnt[1];
    assign win_data      = gnt[1];
    assign any_gnt       = |gnt;

    // RAM request mux: out-of-range accesses are granted but never reach the RAM.
    assign sel_addr      = win_data ? bus.data_addr : bus.instr_addr;
    assign sel_ok        = in_range(sel_addr);
    assign bus.ram_en    = any_gnt && sel_ok;
    assign bus.ram_addr  = sel_addr[ADDR_WIDTH-1:0];
    assign bus.ram_we    = bus.ram_en && win_data && bus.data_we;
    assign bus.ram_be    = win_data ? bus.data_be : 4'hF;
    assign bus.ram_wdata = win_data ? bus.data_wdata : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_q <= '{valid: 1'b0, port: PORT_INSTR, we: 1'b0, err: 1'b0};
        end else begin
            rsp_q.valid <= any_gnt;
            rsp_q.port  <= win_data ? PORT_DATA : PORT_INSTR;
            rsp_q.we    <= win_data && bus.data_we;
            rsp_q.err   <= any_gnt && !sel_ok;
        end
    end

    // Response demux: read data only for an in-range read, zero otherwise.
    assign rsp_rd_ok        = rsp_q.valid && !rsp_q.we && !rsp_q.err;
    assign bus.instr_rvalid = rsp_q.valid && (rsp_q.port == PORT_INSTR);
    assign bus.data_rvalid  = rsp_q.valid && (rsp_q.port == PORT_DATA);
    assign bus.instr_rdata  = (bus.instr_rvalid && rsp_rd_ok) ? bus.ram_rdata : 32'h0;
    assign bus.data_rdata   = (bus.data_rvalid && rsp_rd_ok) ? bus.ram_rdata : 32'h0;
    assign bus.instr_err    = bus.instr_rvalid && rsp_q.err;
    assign bus.data_err     = bus.data_rvalid && rsp_q.err;

endmodule

// File: tb/tb_sp_ram_obi_arb.sv
// Directed bench: round-robin instance with a RAM model, plus a fixed-priority instance for grant order.
module tb_sp_ram_obi_arb;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] mem [0:1023];

    sp_ram_obi_arb_if #(.ADDR_WIDTH(12)) br ();
    sp_ram_obi_arb_if #(.ADDR_WIDTH(12)) bf ();

    sp_ram_obi_arb #(.ADDR_WIDTH(12), .ARB_MODE(0)) dut_rr (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (br)
    );

    sp_ram_obi_arb #(.ADDR_WIDTH(12), .ARB_MODE(1)) dut_fx (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bf)
    );

    assign bf.ram_rdata = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-enabled RAM with one cycle of read latency
    always @(posedge clk) begin
        if (br.ram_en) begin
            if (br.ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (br.ram_be[b]) mem[br.ram_addr[11:2]][8*b +: 8] <= br.ram_wdata[8*b +: 8];
                end
            end
            br.ram_rdata <= mem[br.ram_addr[11:2]];
        end
    end

    task automatic idle_inputs();
        br.instr_req = 1'b0; br.instr_addr = 32'h0;
        br.data_req = 1'b0; br.data_addr = 32'h0; br.data_we = 1'b0;
        br.data_be = 4'h0; br.data_wdata = 32'h0;
        bf.instr_req = 1'b0; bf.instr_addr = 32'h0;
        bf.data_req = 1'b0; bf.data_addr = 32'h0; bf.data_we = 1'b0;
        bf.data_be = 4'h0; bf.data_wdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (br.instr_rvalid !== 1'b0 || br.data_rvalid !== 1'b0 || br.ram_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got irv=%b drv=%b en=%b need 0 0 0", br.instr_rvalid, br.data_rvalid, br.ram_en);
        end
        checks++;
        if (br.instr_err !== 1'b0 || br.data_err !== 1'b0 || br.instr_rdata !== 32'h0 || br.data_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got ierr=%b derr=%b ird=%h drd=%h need zeros", br.instr_err, br.data_err, br.instr_rdata, br.data_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_conflict_rr();
        logic [3:0] exp_data;
        exp_data = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            br.instr_req = 1'b1; br.instr_addr = 32'h10;
            br.data_req = 1'b1; br.data_addr = 32'h40; br.data_we = 1'b0; br.data_be = 4'hF;
            #1;
            checks++;
            if (br.data_gnt !== exp_data[k] || br.instr_gnt !== !exp_data[k]) begin
                failures++;
                $display("FAIL rr_gnt[%0d] got d=%b i=%b need d=%b i=%b", k, br.data_gnt, br.instr_gnt, exp_data[k], !exp_data[k]);
            end
            @(posedge clk); #1;
            checks++;
            if (exp_data[k]) begin
                if (br.data_rvalid !== 1'b1 || br.instr_rvalid !== 1'b0 || br.data_rdata !== 32'hA000_0010) begin
                    failures++;
                    $display("FAIL rr_rsp[%0d] got drv=%b irv=%b drd=%h need 1 0 a0000010", k, br.data_rvalid, br.instr_rvalid, br.data_rdata);
                end
            end else begin
                if (br.instr_rvalid !== 1'b1 || br.data_rvalid !== 1'b0 || br.instr_rdata !== 32'hDEAD_BEEF) begin
                    failures++;
                    $display("FAIL rr_rsp[%0d] got irv=%b drv=%b ird=%h need 1 0 deadbeef", k, br.instr_rvalid, br.data_rvalid, br.instr_rdata);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_fetch();
        @(negedge clk);
        br.instr_req = 1'b1; br.instr_addr = 32'h10;
        #1;
        checks++;
        if (br.instr_gnt !== 1'b1 || br.data_gnt !== 1'b0 || br.ram_en !== 1'b1 ||
            br.ram_addr !== 12'h010 || br.ram_be !== 4'hF || br.ram_we !== 1'b0) begin
            failures++;
            $display("FAIL fetch_req got ig=%b dg=%b en=%b a=%h be=%h we=%b need 1 0 1 010 f 0",
                     br.instr_gnt, br.data_gnt, br.ram_en, br.ram_addr, br.ram_be, br.ram_we);
        end
        @(posedge clk); #1;
        checks++;
        if (br.instr_rvalid !== 1'b1 || br.instr_rdata !== 32'hDEAD_BEEF || br.instr_err !== 1'b0 || br.data_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_rsp got irv=%b ird=%h ierr=%b drv=%b need 1 deadbeef 0 0",
                     br.instr_rvalid, br.instr_rdata, br.instr_err, br.data_rvalid);
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (br.instr_rvalid !== 1'b0 || br.instr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL fetch_idle got irv=%b ird=%h need 0 00000000", br.instr_rvalid, br.instr_rdata);
        end
    endtask

    task automatic test_conflict_fixed();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bf.instr_req = 1'b1; bf.instr_addr = 32'h10;
            bf.data_req = 1'b1; bf.data_addr = 32'h40; bf.data_be = 4'hF;
            #1;
            checks++;
            if (bf.data_gnt !== 1'b1 || bf.instr_gnt !== 1'b0) begin
                failures++;
                $display("FAIL fx_gnt[%0d] got d=%b i=%b need d=1 i=0", k, bf.data_gnt, bf.instr_gnt);
            end
            @(posedge clk); #1;
            checks++;
            if (bf.data_rvalid !== 1'b1 || bf.instr_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL fx_rsp[%0d] got drv=%b irv=%b need 1 0", k, bf.data_rvalid, bf.instr_rvalid);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic data_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input logic exp_en, input logic exp_err,
                               input logic [31:0] exp_rdata, input string name);
        @(negedge clk);
        br.data_req = 1'b1; br.data_we = we; br.data_addr = addr; br.data_be = be; br.data_wdata = wdata;
        #1;
        checks++;
        if (br.data_gnt !== 1'b1 || br.ram_en !== exp_en || br.ram_we !== (we & exp_en) || (exp_en && br.ram_be !== be)) begin
            failures++;
            $display("FAIL %s_req got g=%b en=%b we=%b be=%h need 1 %b %b %h", name, br.data_gnt, br.ram_en, br.ram_we, br.ram_be, exp_en, we & exp_en, be);
        end
        @(posedge clk); #1;
        checks++;
        if (br.data_rvalid !== 1'b1 || br.data_err !== exp_err || br.data_rdata !== exp_rdata) begin
            failures++;
            $display("FAIL %s_rsp got rv=%b err=%b rd=%h need 1 %b %h", name, br.data_rvalid, br.data_err, br.data_rdata, exp_err, exp_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_byte_write();
        data_access(1'b1, 32'h20, 4'b0010, 32'h0000_AB00, 1'b1, 1'b0, 32'h0, "bw_write");
        data_access(1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 1'b0, 32'h1122_AB44, "bw_read");
    endtask

    task automatic test_out_of_range();
        data_access(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, "oor_write");
        data_access(1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'hA000_0000, "oor_alias");
        @(negedge clk);
        br.instr_req = 1'b1; br.instr_addr = 32'hFFFF_0010;
        #1;
        checks++;
        if (br.instr_gnt !== 1'b1 || br.ram_en !== 1'b0) begin
            failures++;
            $display("FAIL oor_fetch_req got g=%b en=%b need 1 0", br.instr_gnt, br.ram_en);
        end
        @(posedge clk); #1;
        checks++;
        if (br.instr_rvalid !== 1'b1 || br.instr_err !== 1'b1 || br.instr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL oor_fetch_rsp got rv=%b err=%b rd=%h need 1 1 00000000", br.instr_rvalid, br.instr_err, br.instr_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        // Leave last granted = data, then abort an instruction access with reset
        @(negedge clk);
        br.data_req = 1'b1; br.data_addr = 32'h40; br.data_be = 4'hF;
        @(negedge clk);
        idle_inputs();
        br.instr_req = 1'b1; br.instr_addr = 32'h10;
        #1;
        checks++;
        if (br.instr_gnt !== 1'b1) begin
            failures++;
            $display("FAIL mid_gnt got %b need 1", br.instr_gnt);
        end
        #2;
        rst_n = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (br.instr_rvalid !== 1'b0 || br.data_rvalid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL mid_rvalid got rvalid seen=%b need 0", seen);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (br.instr_rvalid !== 1'b0 || br.data_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_after got irv=%b drv=%b need 0 0", br.instr_rvalid, br.data_rvalid);
        end
        @(negedge clk);
        br.instr_req = 1'b1; br.instr_addr = 32'h10;
        br.data_req = 1'b1; br.data_addr = 32'h40; br.data_be = 4'hF;
        #1;
        checks++;
        if (br.data_gnt !== 1'b1 || br.instr_gnt !== 1'b0) begin
            failures++;
            $display("FAIL mid_first_conflict got d=%b i=%b need d=1 i=0", br.data_gnt, br.instr_gnt);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        mem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'h1122_3344;
        br.ram_rdata = 32'h0;
        rst_n = 1'b1;
        idle_inputs();
        test_reset();
        test_conflict_rr();
        test_fetch();
        test_conflict_fixed();
        test_byte_write();
        test_out_of_range();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
